memory_responder: RTL

Word-addressed 16-bit program/data memory that answers the processor's memory interface. It is the responder end: it accepts the address, the write data (`mem_in`) and `wr_en`/`rd_en` from the processor, and returns read data on `M`. After reset it first runs a boot phase that streams a program image in over a valid/ready load port. Only then does it accept processor requests. Read latency is configurable, and all request/response timing uses a `ready`/`rvalid` handshake.

---
 rtl/memory_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// memory_responder: word-addressed 16-bit program/data memory on the responder side of the
// processor memory interface. After reset it runs a boot phase that streams a program image in
// over a valid/ready load port. It then serves single-beat writes and latency-configurable reads.
// Reads complete with a one-cycle rvalid pulse.

module memory_responder #(
    parameter int unsigned DEPTH      = 4096,  // implemented words, 1..4096
    parameter int unsigned READ_LAT   = 2,     // accept-to-rvalid cycles, 1..15
    parameter int unsigned LOAD_WORDS = 16     // boot image limit, 0 skips boot
) (
    input  logic        clk,
    input  logic        rst_n,
    // processor request side
    input  logic [11:0] addr,
    input  logic [15:0] mem_in,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [15:0] M,
    output logic        ready,
    output logic        rvalid,
    output logic        err,
    // boot load port
    input  logic        ld_valid,
    input  logic [15:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        boot_done
);

    localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [12:0] DEPTH_W     = 13'(DEPTH);
    localparam bit          BOOT_EN     = (LOAD_WORDS > 0);
    localparam logic [11:0] LD_LAST_PTR = BOOT_EN ? 12'(LOAD_WORDS - 1) : 12'd0;
    localparam logic [3:0]  LAT_INIT    = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {
        StBoot,
        StIdle,
        StRwait,
        StWdone
    } state_e;

    localparam state_e RESET_STATE = BOOT_EN ? StBoot : StIdle;

    state_e      state_q, state_d;
    logic [11:0] ld_ptr_q, ld_ptr_d;
    logic [3:0]  lat_q, lat_d;
    logic [11:0] raddr_q, raddr_d;
    logic [15:0] m_q, m_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic        boot_done_q, boot_done_d;

    // Storage is deliberately outside the reset domain so contents survive a reset.
    logic [15:0] mem_q [DEPTH];
    logic        mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0] mem_wdata;

    logic        addr_in_range;
    logic        raddr_in_range;
    logic [15:0] rdata;

    assign addr_in_range  = ({1'b0, addr} < DEPTH_W);
    assign raddr_in_range = ({1'b0, raddr_q} < DEPTH_W);
    assign rdata          = mem_q[raddr_q[AW-1:0]];

    // Next-state, memory write port and response computation.
    always_comb begin
        state_d     = state_q;
        ld_ptr_d    = ld_ptr_q;
        lat_d       = lat_q;
        raddr_d     = raddr_q;
        m_d         = m_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        boot_done_d = boot_done_q;
        mem_we      = 1'b0;
        mem_waddr   = addr[AW-1:0];
        mem_wdata   = mem_in;

        unique case (state_q)
            StBoot: begin
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ld_ptr_q[AW-1:0];
                    mem_wdata = ld_data;
                    // Pointer stops on the final word so it never exceeds LOAD_WORDS-1.
                    if (ld_last || (ld_ptr_q == LD_LAST_PTR)) begin
                        state_d     = StIdle;
                        boot_done_d = 1'b1;
                    end else begin
                        ld_ptr_d = ld_ptr_q + 12'd1;
                    end
                end
            end
            StIdle: begin
                // Write wins over a simultaneous read; that read is dropped.
                if (wr_en) begin
                    state_d = StWdone;
                    if (addr_in_range) begin
                        mem_we = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (rd_en) begin
                    raddr_d = addr;
                    lat_d   = LAT_INIT;
                    state_d = StRwait;
                end
            end
            StRwait: begin
                if (lat_q == 4'd0) begin
                    state_d  = StIdle;
                    rvalid_d = 1'b1;
                    if (raddr_in_range) begin
                        m_d = rdata;
                    end else begin
                        m_d   = 16'h0000;
                        err_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            StWdone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Control and response registers; reset aborts any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            ld_ptr_q    <= 12'd0;
            lat_q       <= 4'd0;
            raddr_q     <= 12'd0;
            m_q         <= 16'h0000;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            boot_done_q <= !BOOT_EN;
        end else begin
            state_q     <= state_d;
            ld_ptr_q    <= ld_ptr_d;
            lat_q       <= lat_d;
            raddr_q     <= raddr_d;
            m_q         <= m_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            boot_done_q <= boot_done_d;
        end
    end

    // Memory array write; rst_n gate keeps inputs seen during reset from landing in storage.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Handshake outputs decode the state register only.
    assign ready     = (state_q == StIdle);
    assign ld_ready  = (state_q == StBoot);
    assign M         = m_q;
    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign boot_done = boot_done_q;

endmodule
